// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: arbiter state encoding, address field
// widths and the SDRAM command encodings used by the init/refresh/write/read blocks.
package sdram_pkg;

  localparam int unsigned BANK_W       = 2;
  localparam int unsigned ROW_W        = 13;
  localparam int unsigned COL_W        = 9;
  localparam int unsigned SDRAM_ADDR_W = BANK_W + ROW_W + COL_W;

  typedef enum logic [1:0] {
    ARB_INIT = 2'd0,
    ARB_IDLE = 2'd1,
    ARB_AREF = 2'd2,
    ARB_XFER = 2'd3
  } arb_state_t;

  // Command bus ordering is {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
  localparam logic [3:0] CMD_READ      = 4'b0101;
  localparam logic [3:0] CMD_WRITE     = 4'b0100;
  localparam logic [3:0] CMD_BSTOP     = 4'b0110;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_AREF      = 4'b0001;
  localparam logic [3:0] CMD_MREG_SET  = 4'b0000;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first set request scanning
// upward from ptr+1 (modulo N).
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     sel_oh_c,
  output logic [IDX_W-1:0] sel_idx_c,
  output logic             any_c
);

  int               pos;
  logic [IDX_W-1:0] idx;

  // Scan from the lowest priority up so the highest-priority hit is written last
  always_comb begin
    sel_oh_c  = '0;
    sel_idx_c = '0;
    any_c     = |req;
    pos       = 0;
    idx       = '0;
    for (int k = int'(N); k >= 1; k--) begin
      pos = (int'(ptr) + k) % int'(N);
      idx = IDX_W'(pos);
      if (req[idx]) begin
        sel_idx_c = idx;
      end
    end
    sel_oh_c[sel_idx_c] = any_c;
  end

endmodule

// File: rtl/sdram_mport_arbit.sv
// N-port front-end arbiter for the SDRAM controller: round-robin grant of user
// bursts to the single command engine, with auto-refresh taking priority.
module sdram_mport_arbit
  import sdram_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned ADDR_W    = SDRAM_ADDR_W,
  parameter int unsigned BURST_W   = 10,
  parameter int unsigned MAX_BURST = 512
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           init_end,
  input  logic                           aref_req,
  input  logic                           aref_end,
  output logic                           aref_en,
  input  logic [NUM_PORTS-1:0]           port_req,
  input  logic [NUM_PORTS-1:0]           port_we,
  input  logic [NUM_PORTS*ADDR_W-1:0]    port_addr,
  input  logic [NUM_PORTS*BURST_W-1:0]   port_burst_len,
  output logic [NUM_PORTS-1:0]           port_gnt,
  output logic [NUM_PORTS-1:0]           port_done,
  output logic                           cmd_valid,
  output logic                           cmd_we,
  output logic [ADDR_W-1:0]              cmd_addr,
  output logic [BURST_W-1:0]             cmd_burst_len,
  input  logic                           cmd_end
);

  localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  arb_state_t           state_q, state_nxt;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_nxt;
  logic [IDX_W-1:0]     sel_q, sel_nxt;

  logic                 aref_en_nxt;
  logic [NUM_PORTS-1:0] gnt_nxt, done_nxt;
  logic                 valid_nxt, we_nxt;
  logic [ADDR_W-1:0]    addr_nxt;
  logic [BURST_W-1:0]   len_nxt;

  logic [NUM_PORTS-1:0] pick_oh_c;
  logic [IDX_W-1:0]     pick_idx_c;
  logic                 pick_any_c;

  logic [ADDR_W-1:0]    addr_arr [NUM_PORTS];
  logic [BURST_W-1:0]   len_arr  [NUM_PORTS];
  logic [BURST_W-1:0]   len_raw_c, len_clamp_c;

  rr_pick #(
    .N     (NUM_PORTS),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req       (port_req),
    .ptr       (rr_ptr_q),
    .sel_oh_c  (pick_oh_c),
    .sel_idx_c (pick_idx_c),
    .any_c     (pick_any_c)
  );

  // Unpack the flat per-port buses
  always_comb begin
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      addr_arr[i] = port_addr[i*ADDR_W +: ADDR_W];
      len_arr[i]  = port_burst_len[i*BURST_W +: BURST_W];
    end
  end

  // Zero-length bursts become 1; anything beyond one page is cut to a page
  always_comb begin
    len_raw_c   = len_arr[pick_idx_c];
    len_clamp_c = len_raw_c;
    if (len_raw_c == '0) begin
      len_clamp_c = BURST_W'(1);
    end else if (len_raw_c > BURST_W'(MAX_BURST)) begin
      len_clamp_c = BURST_W'(MAX_BURST);
    end
  end

  always_comb begin
    state_nxt   = state_q;
    rr_ptr_nxt  = rr_ptr_q;
    sel_nxt     = sel_q;
    aref_en_nxt = 1'b0;
    gnt_nxt     = '0;
    done_nxt    = '0;
    valid_nxt   = 1'b0;
    we_nxt      = cmd_we;
    addr_nxt    = cmd_addr;
    len_nxt     = cmd_burst_len;
    unique case (state_q)
      ARB_INIT: begin
        if (init_end) state_nxt = ARB_IDLE;
      end
      ARB_IDLE: begin
        if (aref_req) begin
          state_nxt   = ARB_AREF;
          aref_en_nxt = 1'b1;
        end else if (pick_any_c) begin
          state_nxt = ARB_XFER;
          sel_nxt   = pick_idx_c;
          gnt_nxt   = pick_oh_c;
          valid_nxt = 1'b1;
          we_nxt    = port_we[pick_idx_c];
          addr_nxt  = addr_arr[pick_idx_c];
          len_nxt   = len_clamp_c;
        end
      end
      ARB_AREF: begin
        if (aref_end) state_nxt = ARB_IDLE;
        else          aref_en_nxt = 1'b1;
      end
      ARB_XFER: begin
        // Bursts are never preempted; refresh waits for the engine to finish
        if (cmd_end) begin
          state_nxt  = ARB_IDLE;
          done_nxt   = port_gnt;
          rr_ptr_nxt = sel_q;
        end else begin
          gnt_nxt = port_gnt;
        end
      end
      default: state_nxt = ARB_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ARB_INIT;
      rr_ptr_q      <= IDX_W'(NUM_PORTS - 1);
      sel_q         <= '0;
      aref_en       <= 1'b0;
      port_gnt      <= '0;
      port_done     <= '0;
      cmd_valid     <= 1'b0;
      cmd_we        <= 1'b0;
      cmd_addr      <= '0;
      cmd_burst_len <= '0;
    end else begin
      state_q       <= state_nxt;
      rr_ptr_q      <= rr_ptr_nxt;
      sel_q         <= sel_nxt;
      aref_en       <= aref_en_nxt;
      port_gnt      <= gnt_nxt;
      port_done     <= done_nxt;
      cmd_valid     <= valid_nxt;
      cmd_we        <= we_nxt;
      cmd_addr      <= addr_nxt;
      cmd_burst_len <= len_nxt;
    end
  end

endmodule

// File: tb/tb_sdram_mport_arbit.sv
// Directed bench for sdram_mport_arbit: per-cycle vector table for refresh and
// stray-pulse behaviour, plus hand sequences for init, round-robin, clamp and reset.
module tb_sdram_mport_arbit;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 24;
  localparam int unsigned BW = 10;

  logic            clk = 1'b0;
  logic            rst_n, init_end, aref_req, aref_end, cmd_end;
  logic [N-1:0]    port_req, port_we;
  logic [N*AW-1:0] port_addr;
  logic [N*BW-1:0] port_burst_len;
  logic            aref_en, cmd_valid, cmd_we;
  logic [N-1:0]    port_gnt, port_done;
  logic [AW-1:0]   cmd_addr;
  logic [BW-1:0]   cmd_burst_len;

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW-1:0] addr_tab [N];

  typedef struct {
    logic [3:0] req;
    logic       aref;
    logic       aend;
    logic       cend;
    logic [3:0] gnt;
    logic [3:0] done;
    logic       valid;
    logic       aen;
  } vec_t;

  vec_t vt [16];

  always #5 clk = ~clk;

  sdram_mport_arbit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .init_end       (init_end),
    .aref_req       (aref_req),
    .aref_end       (aref_end),
    .aref_en        (aref_en),
    .port_req       (port_req),
    .port_we        (port_we),
    .port_addr      (port_addr),
    .port_burst_len (port_burst_len),
    .port_gnt       (port_gnt),
    .port_done      (port_done),
    .cmd_valid      (cmd_valid),
    .cmd_we         (cmd_we),
    .cmd_addr       (cmd_addr),
    .cmd_burst_len  (cmd_burst_len),
    .cmd_end        (cmd_end)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    port_req = '0;
    aref_req = 1'b0;
    aref_end = 1'b0;
    cmd_end  = 1'b0;
    init_end = 1'b0;
    step();
    step();
    rst_n    = 1'b1;
    init_end = 1'b1;
    step();
  endtask

  task automatic wait_gnt(input string name);
    int c;
    c = 0;
    do begin
      step();
      c++;
    end while (port_gnt == '0 && c < 20);
    check({name, ".gnt_seen"}, 32'(port_gnt != '0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic        seen;
    int          p;
    logic [BW-1:0] clamp_in  [5];
    logic [BW-1:0] clamp_exp [5];

    addr_tab = '{24'hA00000, 24'hA01111, 24'hB02222, 24'hC03333};
    for (int i = 0; i < int'(N); i++) begin
      port_addr[i*AW +: AW]      = addr_tab[i];
      port_burst_len[i*BW +: BW] = BW'(i + 5);
    end
    port_we  = 4'b0101;
    port_req = '0;
    aref_req = 1'b0;
    aref_end = 1'b0;
    cmd_end  = 1'b0;
    init_end = 1'b0;
    rst_n    = 1'b1;
    #2 rst_n = 1'b0;
    step();
    step();

    // Reset values
    check("rst.gnt",   32'(port_gnt),      32'd0);
    check("rst.done",  32'(port_done),     32'd0);
    check("rst.valid", 32'(cmd_valid),     32'd0);
    check("rst.we",    32'(cmd_we),        32'd0);
    check("rst.addr",  32'(cmd_addr),      32'd0);
    check("rst.len",   32'(cmd_burst_len), 32'd0);
    check("rst.aref",  32'(aref_en),       32'd0);

    // Init gating
    rst_n    = 1'b1;
    port_req = 4'b0001;
    seen     = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      seen = seen | (|port_gnt) | cmd_valid;
    end
    check("init.no_gnt", 32'(seen), 32'd0);
    init_end = 1'b1;
    step();
    check("init.gnt_t1", 32'(port_gnt), 32'd0);
    step();
    check("init.gnt_t2",   32'(port_gnt),  32'h1);
    check("init.valid_t2", 32'(cmd_valid), 32'd1);
    check("init.addr",     32'(cmd_addr),  32'(addr_tab[0]));
    cmd_end = 1'b1;
    step();
    cmd_end  = 1'b0;
    port_req = '0;
    check("init.done", 32'(port_done), 32'h1);

    // Round-robin with all ports requesting
    do_reset();
    port_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      p = k % 4;
      wait_gnt($sformatf("rr%0d", k));
      check($sformatf("rr%0d.gnt", k),   32'(port_gnt),      32'd1 << p);
      check($sformatf("rr%0d.valid", k), 32'(cmd_valid),     32'd1);
      check($sformatf("rr%0d.addr", k),  32'(cmd_addr),      32'(addr_tab[p]));
      check($sformatf("rr%0d.we", k),    32'(cmd_we),        32'(port_we[p]));
      check($sformatf("rr%0d.len", k),   32'(cmd_burst_len), 32'(p + 5));
      repeat (9) step();
      cmd_end = 1'b1;
      step();
      cmd_end = 1'b0;
      check($sformatf("rr%0d.done", k),    32'(port_done), 32'd1 << p);
      check($sformatf("rr%0d.gnt_off", k), 32'(port_gnt),  32'd0);
    end

    // Refresh priority and stray pulses, one row per cycle
    vt[0]  = '{4'b0100, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1};
    vt[1]  = '{4'b0100, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1};
    vt[2]  = '{4'b0100, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0};
    vt[3]  = '{4'b0100, 1'b0, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b0};
    vt[4]  = '{4'b0100, 1'b0, 1'b1, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b0};
    vt[5]  = '{4'b0100, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0100, 1'b0, 1'b0};
    vt[6]  = '{4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0};
    vt[7]  = '{4'b0010, 1'b0, 1'b0, 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b0};
    vt[8]  = '{4'b0010, 1'b1, 1'b0, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b0};
    vt[9]  = '{4'b1010, 1'b1, 1'b0, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b0};
    vt[10] = '{4'b1010, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0010, 1'b0, 1'b0};
    vt[11] = '{4'b1000, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1};
    vt[12] = '{4'b1000, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0};
    vt[13] = '{4'b1000, 1'b0, 1'b0, 1'b0, 4'b1000, 4'b0000, 1'b1, 1'b0};
    vt[14] = '{4'b1000, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b1000, 1'b0, 1'b0};
    vt[15] = '{4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 16; i++) begin
      port_req = vt[i].req;
      aref_req = vt[i].aref;
      aref_end = vt[i].aend;
      cmd_end  = vt[i].cend;
      step();
      check($sformatf("vec%0d.gnt", i),   32'(port_gnt),  32'(vt[i].gnt));
      check($sformatf("vec%0d.done", i),  32'(port_done), 32'(vt[i].done));
      check($sformatf("vec%0d.valid", i), 32'(cmd_valid), 32'(vt[i].valid));
      check($sformatf("vec%0d.aref", i),  32'(aref_en),   32'(vt[i].aen));
    end
    aref_end = 1'b0;
    port_req = '0;

    // Burst length clamping and command latching on port 3
    clamp_in  = '{10'd0, 10'd1023, 10'd512, 10'd513, 10'd7};
    clamp_exp = '{10'd1, 10'd512,  10'd512, 10'd512, 10'd7};
    do_reset();
    port_req = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      port_burst_len[3*BW +: BW] = clamp_in[i];
      wait_gnt($sformatf("clamp%0d", i));
      check($sformatf("clamp%0d.gnt", i), 32'(port_gnt),      32'h8);
      check($sformatf("clamp%0d.len", i), 32'(cmd_burst_len), 32'(clamp_exp[i]));
      if (i == 0) begin
        port_addr[3*AW +: AW]      = 24'h5A5A5A;
        port_burst_len[3*BW +: BW] = 10'd99;
        step();
        check("latch.addr", 32'(cmd_addr),      32'(addr_tab[3]));
        check("latch.len",  32'(cmd_burst_len), 32'd1);
        port_addr[3*AW +: AW] = addr_tab[3];
      end
      cmd_end = 1'b1;
      step();
      cmd_end = 1'b0;
      check($sformatf("clamp%0d.done", i), 32'(port_done), 32'h8);
    end
    port_req = '0;

    // Asynchronous reset in the middle of a port 2 burst
    do_reset();
    port_req = 4'b0100;
    wait_gnt("arst");
    check("arst.gnt_before", 32'(port_gnt), 32'h4);
    #2 rst_n = 1'b0;
    #1;
    check("arst.gnt",   32'(port_gnt),      32'd0);
    check("arst.valid", 32'(cmd_valid),     32'd0);
    check("arst.we",    32'(cmd_we),        32'd0);
    check("arst.addr",  32'(cmd_addr),      32'd0);
    check("arst.len",   32'(cmd_burst_len), 32'd0);
    check("arst.aref",  32'(aref_en),       32'd0);
    init_end = 1'b0;
    port_req = 4'b0101;
    #1 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      seen = seen | (|port_gnt);
    end
    check("arst.init_gate", 32'(seen), 32'd0);
    init_end = 1'b1;
    step();
    check("arst.gnt_t1", 32'(port_gnt), 32'd0);
    step();
    check("arst.gnt_p0", 32'(port_gnt),  32'h1);
    check("arst.valid2", 32'(cmd_valid), 32'd1);
    check("arst.addr2",  32'(cmd_addr),  32'(addr_tab[0]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
